// File: rtl/ternary_mac_sequencer.sv
// ternary_mac_sequencer - job controller for the N_ROWS ternary MAC systolic array:
// clear, admit K operand beats, snapshot the accumulators, then stream the N_ROWS results.
module ternary_mac_sequencer #(
  parameter int N_ROWS = 4,
  parameter int ACC_W  = 17,
  parameter int IN_W   = 8,
  parameter int K_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [K_W-1:0]            cfg_k,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      out_ready,
  output logic                      acc_clear,
  output logic                      mac_en,
  output logic                      copy_to_q,
  output logic                      restart_q,
  output logic                      out_valid,
  output logic [$clog2(N_ROWS)-1:0] out_idx,
  output logic                      busy,
  output logic                      done,
  output logic                      k_clipped
);

  localparam int IDX_W = $clog2(N_ROWS);
  // Largest beat count whose worst-case sum still fits in ACC_W.
  localparam logic [K_W-1:0]   K_SAFE   = K_W'((1 << (ACC_W - IN_W)) - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ACCUM, S_COPY, S_READOUT, S_DONE
  } state_t;

  state_t         state, state_nx;
  logic [K_W-1:0] k_eff;
  logic [K_W-1:0] beat_cnt;
  logic           beat, last_beat, xfer, last_xfer;

  assign beat      = (state == S_ACCUM) && in_valid;
  assign last_beat = beat && (beat_cnt == k_eff - K_W'(1));
  assign xfer      = (state == S_READOUT) && out_ready;
  assign last_xfer = xfer && (out_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k_eff     <= '0;
      beat_cnt  <= '0;
      out_idx   <= '0;
      k_clipped <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        k_eff     <= (cfg_k > K_SAFE) ? K_SAFE : cfg_k;
        k_clipped <= (cfg_k > K_SAFE);
        beat_cnt  <= '0;
        out_idx   <= '0;
      end
      if (beat) beat_cnt <= beat_cnt + K_W'(1);
      if (xfer) out_idx <= last_xfer ? '0 : out_idx + IDX_W'(1);
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    acc_clear = 1'b0;
    mac_en    = 1'b0;
    copy_to_q = 1'b0;
    restart_q = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        restart_q = 1'b1;
        if (start) state_nx = S_CLEAR;
      end
      S_CLEAR: begin
        acc_clear = 1'b1;
        state_nx  = (k_eff != '0) ? S_ACCUM : S_COPY;
      end
      S_ACCUM: begin
        // Stall cycles must leave the accumulators untouched, so the gate follows in_valid.
        in_ready = 1'b1;
        mac_en   = in_valid;
        if (last_beat) state_nx = S_COPY;
      end
      S_COPY: begin
        copy_to_q = 1'b1;
        restart_q = 1'b1;
        state_nx  = S_READOUT;
      end
      S_READOUT: begin
        out_valid = 1'b1;
        if (last_xfer) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
